// File: rtl/acc_seq_pkg.sv
// Shared types and constants for the 4x4 window accumulate sequencer.
//   state_e       : sequencer FSM states
//   WIN_DIM       : window edge length (rows == columns)
//   WIN_ELEMS     : elements per window
//   LANES         : accumulator lanes, one per window row
//   REDUCE_SHIFT  : log2(WIN_ELEMS), turns the 4-lane total into the average
package acc_seq_pkg;

    localparam int unsigned WIN_DIM      = 4;
    localparam int unsigned WIN_ELEMS    = WIN_DIM * WIN_DIM;
    localparam int unsigned LANES        = WIN_DIM;
    localparam int unsigned REDUCE_SHIFT = 4;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ACC_W  = 12;
    localparam int unsigned LANE_W = $clog2(LANES);
    localparam int unsigned COL_W  = $clog2(WIN_DIM);
    // One extra bit so the counter can hold WIN_ELEMS itself (all reads issued).
    localparam int unsigned CNT_W  = $clog2(WIN_ELEMS) + 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_READ   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_REDUCE = 3'd4
    } state_e;

endpackage : acc_seq_pkg

// File: rtl/acc_window_seq_if.sv
// Bundle of control, memory-read and accumulator-strobe signals.
//   master : the sequencer (drives memory reads and accumulator strobes)
//   slave  : the environment (requests windows, supplies memory data)
// Signals: start, base_addr, mem_rd, mem_addr, mem_rdata, acc_clr, add_en,
//          lane_sel, add_data, busy, done, abort (only with ACC_WINDOW_SEQ_ABORT_EN).
interface acc_window_seq_if #(
    parameter int unsigned ADDR_W = 10
);
    import acc_seq_pkg::*;

    logic                start;
    logic [ADDR_W-1:0]   base_addr;
    logic                mem_rd;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_rdata;
    logic                acc_clr;
    logic                add_en;
    logic [LANE_W-1:0]   lane_sel;
    logic [DATA_W-1:0]   add_data;
    logic                busy;
    logic                done;
`ifdef ACC_WINDOW_SEQ_ABORT_EN
    logic                abort;

    modport master (
        input  start, base_addr, mem_rdata, abort,
        output mem_rd, mem_addr, acc_clr, add_en, lane_sel, add_data, busy, done
    );

    modport slave (
        output start, base_addr, mem_rdata, abort,
        input  mem_rd, mem_addr, acc_clr, add_en, lane_sel, add_data, busy, done
    );
`else
    modport master (
        input  start, base_addr, mem_rdata,
        output mem_rd, mem_addr, acc_clr, add_en, lane_sel, add_data, busy, done
    );

    modport slave (
        output start, base_addr, mem_rdata,
        input  mem_rd, mem_addr, acc_clr, add_en, lane_sel, add_data, busy, done
    );
`endif

endinterface : acc_window_seq_if

// File: rtl/acc_win_addr_gen.sv
// Window element counter and row/column to byte-address translation.
//   clk, rst : clock, asynchronous active-low reset
//   load_i   : capture base_i and restart the element count at 0
//   base_i   : address of window element (0,0)
//   step_i   : advance to the next element
//   addr_o   : address of the current element (wraps modulo 2^ADDR_W)
//   row_o    : window row of the current element (accumulator lane)
//   last_o   : all WIN_ELEMS elements have been stepped past
module acc_win_addr_gen
    import acc_seq_pkg::*;
#(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned ROW_STRIDE = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic              step_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [LANE_W-1:0] row_o,
    output logic              last_o
);

    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] base_d;
    logic [COL_W-1:0]  col_c;

    // Element index n maps to row n[3:2], column n[1:0].
    assign row_o  = cnt_q[COL_W +: LANE_W];
    assign col_c  = cnt_q[COL_W-1:0];
    assign last_o = (cnt_q == CNT_W'(WIN_ELEMS));

    // Sum is kept at ADDR_W bits so a window crossing the top of memory wraps.
    assign addr_o = base_q
                  + ADDR_W'(row_o) * ADDR_W'(ROW_STRIDE)
                  + ADDR_W'(col_c);

    // Next count/base: load wins over step.
    always_comb begin
        cnt_d  = cnt_q;
        base_d = base_q;
        if (load_i) begin
            cnt_d  = '0;
            base_d = base_i;
        end else if (step_i) begin
            cnt_d  = cnt_q + CNT_W'(1);
        end
    end

    // Counter and base registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            base_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            base_q <= base_d;
        end
    end

endmodule : acc_win_addr_gen

// File: rtl/acc_window_seq.sv
// Sequencer that reads a 4x4 byte window from memory and streams each byte
// into one of four external 12-bit row accumulators, then flags the average.
//   clk   : clock, all state on rising edge
//   rst   : asynchronous active-low reset
//   bus   : acc_window_seq_if.master
//           start/base_addr in, mem_rd/mem_addr out, mem_rdata in,
//           acc_clr/add_en/lane_sel/add_data out, busy/done out,
//           abort in when ACC_WINDOW_SEQ_ABORT_EN is defined.
// Optional feature macro: ACC_WINDOW_SEQ_ABORT_EN (adds the abort input).
// Timing: start sampled at edge 0 -> CLEAR, 16 READ cycles, DRAIN, REDUCE
// (done) in the 19th cycle after the start cycle.
module acc_window_seq
    import acc_seq_pkg::*;
#(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned ROW_STRIDE = 32
) (
    input  logic              clk,
    input  logic              rst,
    acc_window_seq_if.master  bus
);

    state_e            state_q;
    state_e            state_d;
    logic              mem_rd_q;
    logic              mem_rd_d;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [ADDR_W-1:0] mem_addr_d;
    logic              acc_clr_q;
    logic              acc_clr_d;
    logic              add_en_q;
    logic              add_en_d;
    logic [LANE_W-1:0] lane_q;
    logic [LANE_W-1:0] lane_d;
    logic [LANE_W-1:0] rd_row_q;
    logic [LANE_W-1:0] rd_row_d;
    logic              done_q;
    logic              done_d;

    logic              gen_load_c;
    logic              gen_step_c;
    logic [ADDR_W-1:0] gen_addr;
    logic [LANE_W-1:0] gen_row;
    logic              gen_last;
    logic              abort_c;

`ifdef ACC_WINDOW_SEQ_ABORT_EN
    assign abort_c = bus.abort;
`else
    assign abort_c = 1'b0;
`endif

    acc_win_addr_gen #(
        .ADDR_W     (ADDR_W),
        .ROW_STRIDE (ROW_STRIDE)
    ) u_addr_gen (
        .clk    (clk),
        .rst    (rst),
        .load_i (gen_load_c),
        .base_i (bus.base_addr),
        .step_i (gen_step_c),
        .addr_o (gen_addr),
        .row_o  (gen_row),
        .last_o (gen_last)
    );

    // Next state and next registered outputs.
    always_comb begin
        state_d    = state_q;
        mem_rd_d   = 1'b0;
        mem_addr_d = '0;
        acc_clr_d  = 1'b0;
        add_en_d   = 1'b0;
        lane_d     = '0;
        rd_row_d   = '0;
        done_d     = 1'b0;
        gen_load_c = 1'b0;
        gen_step_c = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d    = ST_CLEAR;
                    acc_clr_d  = 1'b1;
                    gen_load_c = 1'b1;
                end
            end

            // Accumulators clear this cycle; the first read is issued for next cycle.
            ST_CLEAR: begin
                state_d    = ST_READ;
                mem_rd_d   = 1'b1;
                mem_addr_d = gen_addr;
                rd_row_d   = gen_row;
                gen_step_c = 1'b1;
            end

            // Each read seen on the bus this cycle becomes an add strobe next
            // cycle, when its data returns; its row travels with it.
            ST_READ: begin
                add_en_d = mem_rd_q;
                lane_d   = rd_row_q;
                if (gen_last) begin
                    state_d = ST_DRAIN;
                end else begin
                    mem_rd_d   = 1'b1;
                    mem_addr_d = gen_addr;
                    rd_row_d   = gen_row;
                    gen_step_c = 1'b1;
                end
            end

            // Final add strobe is on the bus now; the average is ready next cycle.
            ST_DRAIN: begin
                state_d = ST_REDUCE;
                done_d  = 1'b1;
            end

            ST_REDUCE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort cancels everything in flight, including the pending add strobe.
        if (abort_c && (state_q != ST_IDLE)) begin
            state_d    = ST_IDLE;
            mem_rd_d   = 1'b0;
            mem_addr_d = '0;
            acc_clr_d  = 1'b0;
            add_en_d   = 1'b0;
            lane_d     = '0;
            rd_row_d   = '0;
            done_d     = 1'b0;
            gen_step_c = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            acc_clr_q  <= 1'b0;
            add_en_q   <= 1'b0;
            lane_q     <= '0;
            rd_row_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            acc_clr_q  <= acc_clr_d;
            add_en_q   <= add_en_d;
            lane_q     <= lane_d;
            rd_row_q   <= rd_row_d;
            done_q     <= done_d;
        end
    end

    assign bus.mem_rd   = mem_rd_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.acc_clr  = acc_clr_q;
    assign bus.add_en   = add_en_q;
    assign bus.lane_sel = lane_q;
    // Read data arrives in the add_en cycle, so it is forwarded, gated by the strobe.
    assign bus.add_data = add_en_q ? bus.mem_rdata : '0;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = done_q;

endmodule : acc_window_seq

// File: tb/tb_acc_window_seq.sv
// Testbench for acc_window_seq: byte memory model, four 12-bit accumulators,
// and a reference built from plain window arithmetic.
module tb_acc_window_seq;
    import acc_seq_pkg::*;

    localparam int unsigned ADDR_W     = 10;
    localparam int unsigned ROW_STRIDE = 32;
    localparam int unsigned MEM_SIZE   = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b0;

    acc_window_seq_if #(.ADDR_W(ADDR_W)) bus ();

    acc_window_seq #(
        .ADDR_W     (ADDR_W),
        .ROW_STRIDE (ROW_STRIDE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [MEM_SIZE];
    logic [11:0] acc [LANES];

    int checks = 0;
    int errors = 0;

    // Byte memory with one-cycle read latency.
    always @(posedge clk or negedge rst) begin
        if (!rst) bus.mem_rdata <= '0;
        else if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
    end

    // External row accumulators driven by the DUT strobes.
    always @(posedge clk) begin
        if (bus.acc_clr) begin
            for (int i = 0; i < int'(LANES); i++) acc[i] <= '0;
        end else if (bus.add_en) begin
            acc[bus.lane_sel] <= acc[bus.lane_sel] + 12'(bus.add_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_addr(input int base, input int n);
        return (base + (n / int'(WIN_DIM)) * int'(ROW_STRIDE) + (n % int'(WIN_DIM))) % int'(MEM_SIZE);
    endfunction

    function automatic int ref_lane_sum(input int base, input int lane);
        int s = 0;
        for (int c = 0; c < int'(WIN_DIM); c++) s += int'(mem[ref_addr(base, lane * int'(WIN_DIM) + c)]);
        return s;
    endfunction

    function automatic int acc_total();
        int s = 0;
        for (int i = 0; i < int'(LANES); i++) s += int'(acc[i]);
        return s;
    endfunction

    // Runs one window from the current mid-cycle point; start cycle is cycle 0.
    // g0/g1 are cycles in which a stray start is pulsed while busy.
    // Returns at cycle 20 (mid-cycle), start low.
    task automatic run_window(input int base, input int g0, input int g1);
        int rd_addrs[$];
        int add_cyc[$];
        int lsum[LANES];
        int rd_first = -1, clr_n = 0, clr_cyc = -1, done_n = 0, done_cyc = -1;
        int busy_n = 0, addr_err = 0, avg_obs = -1, ref_total = 0;
        for (int i = 0; i < int'(LANES); i++) lsum[i] = 0;
        bus.start     = 1'b1;
        bus.base_addr = ADDR_W'(base);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
`ifdef ACC_WINDOW_SEQ_ABORT_EN
            bus.abort = 1'b0;
`endif
            bus.start     = (k == g0) || (k == g1);
            bus.base_addr = ADDR_W'($urandom);
            if (bus.acc_clr) begin clr_n++; clr_cyc = k; end
            if (bus.mem_rd) begin
                if (rd_first < 0) rd_first = k;
                rd_addrs.push_back(int'(bus.mem_addr));
            end
            if (bus.add_en) begin
                add_cyc.push_back(k);
                lsum[bus.lane_sel] += int'(bus.add_data);
            end
            if (bus.done) begin
                done_n++;
                done_cyc = k;
                avg_obs  = acc_total() / 16;
            end
            if (k < 20 && bus.busy) busy_n++;
            if (k == 20) check("busy_after_done", 32'(bus.busy), 0);
        end
        bus.start = 1'b0;
        for (int i = 0; i < rd_addrs.size(); i++)
            if (rd_addrs[i] != ref_addr(base, i)) addr_err++;
        check("clr_count", clr_n, 1);
        check("clr_cycle", clr_cyc, 1);
        check("rd_count", rd_addrs.size(), WIN_ELEMS);
        check("rd_first_cycle", rd_first, 2);
        check("rd_addr_errs", addr_err, 0);
        check("add_count", add_cyc.size(), WIN_ELEMS);
        check("add_first_cycle", (add_cyc.size() > 0) ? add_cyc[0] : -1, 3);
        check("add_last_cycle", (add_cyc.size() > 0) ? add_cyc[add_cyc.size()-1] : -1, 18);
        for (int l = 0; l < int'(LANES); l++) begin
            check($sformatf("lane%0d_sum", l), lsum[l], ref_lane_sum(base, l));
            ref_total += ref_lane_sum(base, l);
        end
        check("done_count", done_n, 1);
        check("done_cycle", done_cyc, 19);
        check("busy_cycles", busy_n, 19);
        check("avg", avg_obs, ref_total / 16);
    endtask

    initial begin
        int base;
        int cnt_add, cnt_done, cnt_busy;
        bus.start     = 1'b0;
        bus.base_addr = '0;
`ifdef ACC_WINDOW_SEQ_ABORT_EN
        bus.abort     = 1'b0;
`endif
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_mem_rd", 32'(bus.mem_rd), 0);
        check("reset_mem_addr", 32'(bus.mem_addr), 0);
        check("reset_acc_clr", 32'(bus.acc_clr), 0);
        check("reset_add_en", 32'(bus.add_en), 0);
        check("reset_lane_sel", 32'(bus.lane_sel), 0);
        check("reset_add_data", 32'(bus.add_data), 0);
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_done", 32'(bus.done), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Address-pattern memory, base 0.
        for (int i = 0; i < int'(MEM_SIZE); i++) mem[i] = 8'(i);
        run_window(0, 0, 0);
        check("pat_lane0", 32'(acc[0]), 6);
        check("pat_lane1", 32'(acc[1]), 134);
        check("pat_lane2", 32'(acc[2]), 262);
        check("pat_lane3", 32'(acc[3]), 390);
        check("pat_avg", acc_total() / 16, 49);

        // All 0xFF, started in the cycle right after done.
        for (int i = 0; i < int'(MEM_SIZE); i++) mem[i] = 8'hFF;
        run_window(341, 0, 0);
        check("ff_lane0", 32'(acc[0]), 1020);
        check("ff_lane3", 32'(acc[3]), 1020);
        check("ff_avg", acc_total() / 16, 255);

        // Window crossing the top of memory wraps.
        for (int i = 0; i < int'(MEM_SIZE); i++) mem[i] = 8'(i);
        run_window(1020, 0, 0);
        check("wrap_lane0", 32'(acc[0]), 252 + 253 + 254 + 255);
        check("wrap_lane1", 32'(acc[1]), 28 + 29 + 30 + 31);

        // Stray starts while busy are ignored.
        run_window(int'($urandom_range(0, MEM_SIZE - 1)), 5, 12);

        // Random memory and bases.
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < int'(MEM_SIZE); i++) mem[i] = 8'($urandom);
            repeat (int'($urandom_range(0, 3))) begin @(posedge clk); #1; end
            run_window(int'($urandom_range(0, MEM_SIZE - 1)), 0, 0);
        end

        // Reset in the middle of a window.
        bus.start     = 1'b1;
        bus.base_addr = ADDR_W'($urandom);
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        rst = 1'b0;
        #1;
        check("midrst_mem_rd", 32'(bus.mem_rd), 0);
        check("midrst_mem_addr", 32'(bus.mem_addr), 0);
        check("midrst_acc_clr", 32'(bus.acc_clr), 0);
        check("midrst_add_en", 32'(bus.add_en), 0);
        check("midrst_lane_sel", 32'(bus.lane_sel), 0);
        check("midrst_add_data", 32'(bus.add_data), 0);
        check("midrst_busy", 32'(bus.busy), 0);
        check("midrst_done", 32'(bus.done), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        cnt_add = 0; cnt_done = 0; cnt_busy = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            cnt_add  += int'(bus.add_en);
            cnt_done += int'(bus.done);
            cnt_busy += int'(bus.busy);
        end
        check("postrst_add_en", cnt_add, 0);
        check("postrst_done", cnt_done, 0);
        check("postrst_busy", cnt_busy, 0);
        run_window(int'($urandom_range(0, MEM_SIZE - 1)), 0, 0);

`ifdef ACC_WINDOW_SEQ_ABORT_EN
        // Abort in cycle 10 returns to IDLE with no further strobes.
        bus.start     = 1'b1;
        bus.base_addr = ADDR_W'($urandom);
        cnt_add = 0; cnt_done = 0; cnt_busy = 0;
        for (int k = 1; k <= 22; k++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            bus.abort = (k == 10);
            if (k >= 11) begin
                cnt_add  += int'(bus.add_en);
                cnt_busy += int'(bus.busy);
            end
            cnt_done += int'(bus.done);
        end
        check("abort_add_en", cnt_add, 0);
        check("abort_done", cnt_done, 0);
        check("abort_busy", cnt_busy, 0);
        // Abort together with start in IDLE: start wins.
        bus.abort = 1'b1;
        run_window(int'($urandom_range(0, MEM_SIZE - 1)), 0, 0);
`endif

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_acc_window_seq
